// File: rtl/state_log_reader.sv
// Snapshots four logged state words plus the change flag and streams them out as a byte frame.
// Define STATE_LOG_READER_AUTOCLR_EN to pulse oClear_n low after each complete frame.
module state_log_reader #(
    parameter int BITS = 8
) (
    input  logic            iClk,
    input  logic            iRst_n,
    input  logic            iReq,
    input  logic            iAbort,
    input  logic [BITS-1:0] iState0,
    input  logic [BITS-1:0] iState1,
    input  logic [BITS-1:0] iState2,
    input  logic [BITS-1:0] iState3,
    input  logic            iChange,
    output logic [7:0]      oData,
    output logic            oValid,
    input  logic            iReady,
    output logic            oBusy,
    output logic            oDone,
    output logic            oClear_n
);

    localparam int NB = (BITS + 7) / 8;
    localparam int L  = 1 + 4 * NB;
    localparam int IW = $clog2(L);
    localparam logic [IW-1:0] LAST = IW'(L - 1);

`ifdef STATE_LOG_READER_AUTOCLR_EN
    typedef enum logic [1:0] {IDLE, SEND, CLEAR, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
`endif

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [BITS-1:0] snap_q [4];
    logic            chg_q;
    logic            cap;
    logic            done_q;
    logic [8*L-1:0]  frame;
    logic [8*NB-1:0] word;

    // Flattened frame image, byte 0 in the low bits, words zero-padded
    always_comb begin
        frame      = '0;
        word       = '0;
        frame[7:0] = {4'hA, 3'b000, chg_q};
        for (int w = 0; w < 4; w++) begin
            word                     = '0;
            word[BITS-1:0]           = snap_q[w];
            frame[8+8*NB*w +: 8*NB]  = word;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cap     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (iReq) begin
                    cap     = 1'b1;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (iAbort) begin
                    state_d = IDLE;
                end else if (iReady) begin
                    if (idx_q == LAST) begin
`ifdef STATE_LOG_READER_AUTOCLR_EN
                        state_d = CLEAR;
`else
                        state_d = DONE;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef STATE_LOG_READER_AUTOCLR_EN
            CLEAR: state_d = IDLE;
`endif
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            snap_q[0] <= '0;
            snap_q[1] <= '0;
            snap_q[2] <= '0;
            snap_q[3] <= '0;
            chg_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (cap) begin
                snap_q[0] <= iState0;
                snap_q[1] <= iState1;
                snap_q[2] <= iState2;
                snap_q[3] <= iState3;
                chg_q     <= iChange;
            end
        end
    end

    // Completion strobes come straight from flops so the logger sees clean pulses
`ifdef STATE_LOG_READER_AUTOCLR_EN
    logic clr_n_q;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            done_q  <= 1'b0;
            clr_n_q <= 1'b1;
        end else begin
            done_q  <= (state_d == DONE) || (state_d == CLEAR);
            clr_n_q <= (state_d != CLEAR);
        end
    end

    assign oClear_n = clr_n_q;
`else
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_d == DONE);
        end
    end

    assign oClear_n = 1'b1;
`endif

    assign oDone  = done_q;
    assign oValid = (state_q == SEND);
    assign oBusy  = (state_q != IDLE);
    assign oData  = (state_q == SEND) ? frame[{idx_q, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_state_log_reader.sv
// Bench for state_log_reader: BITS=8 and BITS=12 instances driven in lockstep.
// Table vectors, hand sequences (abort, reset) and random frames against a byte model.
module tb_state_log_reader;

    logic        iClk = 1'b0;
    logic        iRst_n = 1'b0;
    logic        iReq = 1'b0;
    logic        iAbort = 1'b0;
    logic        iChange = 1'b0;
    logic        iReady = 1'b0;
    logic [11:0] s0 = '0, s1 = '0, s2 = '0, s3 = '0;

    logic [7:0]  od [2];
    logic        ov [2];
    logic        ob [2];
    logic        odn [2];
    logic        ocl [2];

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [7:0]  got [2][16];
    int          gn [2];
    int          dn [2];
    int          dcyc [2];

    always #5 iClk = ~iClk;

    state_log_reader #(.BITS(8)) u8 (
        .iClk(iClk), .iRst_n(iRst_n), .iReq(iReq), .iAbort(iAbort),
        .iState0(s0[7:0]), .iState1(s1[7:0]), .iState2(s2[7:0]), .iState3(s3[7:0]),
        .iChange(iChange), .oData(od[0]), .oValid(ov[0]), .iReady(iReady),
        .oBusy(ob[0]), .oDone(odn[0]), .oClear_n(ocl[0])
    );

    state_log_reader #(.BITS(12)) u12 (
        .iClk(iClk), .iRst_n(iRst_n), .iReq(iReq), .iAbort(iAbort),
        .iState0(s0), .iState1(s1), .iState2(s2), .iState3(s3),
        .iChange(iChange), .oData(od[1]), .oValid(ov[1]), .iReady(iReady),
        .oBusy(ob[1]), .oDone(odn[1]), .oClear_n(ocl[1])
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int flen(input int k);
        return (k == 0) ? 5 : 9;
    endfunction

    // Frame from the byte rules: header, then each word little-endian over NB bytes
    function automatic logic [71:0] ref_frame(input int bits, input logic [11:0] a,
            input logic [11:0] b, input logic [11:0] c, input logic [11:0] d, input logic chg);
        logic [11:0] w [4];
        logic [11:0] m;
        logic [71:0] r;
        logic [11:0] v;
        int nb;
        nb = (bits + 7) / 8;
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        m = (bits >= 12) ? 12'hFFF : 12'((1 << bits) - 1);
        r = {64'd0, 4'hA, 3'b000, chg};
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < nb; j++) begin
                v = (w[i] & m) >> (8 * j);
                r = {r[63:0], v[7:0]};
            end
        end
        return r;
    endfunction

    initial forever begin
        @(posedge iClk);
        cyc++;
    end

    // Transfer collector plus per-cycle protocol checks
    initial begin
        logic pst [2];
        logic [7:0] pdat [2];
        logic pdn [2];
        logic exp_cl;
        pst = '{1'b0, 1'b0};
        pdn = '{1'b0, 1'b0};
        pdat = '{8'h00, 8'h00};
        forever begin
            @(negedge iClk);
            for (int k = 0; k < 2; k++) begin
                if (!iRst_n) begin
                    pst[k] = 1'b0;
                    pdn[k] = 1'b0;
                end else begin
                    if (pst[k])
                        check($sformatf("hold%0d", k), {ov[k], od[k]}, {1'b1, pdat[k]});
                    if (ov[k] && iReady) begin
                        if (gn[k] < 16) got[k][gn[k]] = od[k];
                        gn[k]++;
                    end
                    pst[k] = ov[k] && !iReady;
                    pdat[k] = od[k];
                    if (odn[k]) begin
                        dn[k]++;
                        dcyc[k] = cyc;
                    end
`ifdef STATE_LOG_READER_AUTOCLR_EN
                    exp_cl = !odn[k];
`else
                    exp_cl = 1'b1;
`endif
                    check($sformatf("clear_n%0d", k), ocl[k], exp_cl);
                    if (pdn[k]) check($sformatf("done_pulse%0d", k), odn[k], 1'b0);
                    pdn[k] = odn[k];
                end
            end
        end
    end

    task automatic run_frame(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c,
            input logic [11:0] d, input logic chg, input int mode, input bit disturb, output int reqc);
        int t;
        bit to;
        @(posedge iClk); #1;
        s0 = a; s1 = b; s2 = c; s3 = d; iChange = chg;
        gn = '{0, 0};
        dn = '{0, 0};
        iReady = 1'b1;
        iReq = 1'b1;
        @(posedge iClk); #1;
        reqc = cyc;
        iReq = 1'b0;
        t = 0;
        to = 1'b1;
        while (t < 200) begin
            if (!ob[0] && !ob[1]) begin
                to = 1'b0;
                break;
            end
            iReady = (mode == 0) ? 1'b1 : (mode == 1) ? (t % 3 == 0) : 1'($urandom % 2);
            if (disturb) begin
                s0 = 12'($urandom); s1 = 12'($urandom);
                s2 = 12'($urandom); s3 = 12'($urandom);
                iChange = 1'($urandom);
                iReq = ob[0] && ob[1] && ($urandom % 4 == 0);
            end
            @(posedge iClk); #1;
            t++;
        end
        iReq = 1'b0;
        iReady = 1'b1;
        if (to) check("frame_timeout", 1, 0);
    endtask

    task automatic cmp_frame(input string nm, input int k, input logic [71:0] e,
            input int mode, input int reqc);
        int n;
        n = flen(k);
        check($sformatf("%s_len%0d", nm, k), gn[k], n);
        for (int i = 0; i < n && i < gn[k] && i < 16; i++)
            check($sformatf("%s_b%0d_%0d", nm, k, i), got[k][i], e[8*(n-1-i) +: 8]);
        check($sformatf("%s_done%0d", nm, k), dn[k], 1);
        if (mode == 0)
            check($sformatf("%s_lat%0d", nm, k), dcyc[k], reqc + n);
    endtask

    typedef struct {
        logic [11:0] w0, w1, w2, w3;
        logic        chg;
        logic [39:0] e8;
        logic [71:0] e12;
    } vec_t;

    initial begin
        vec_t vt [3];
        int reqc;
        int mode;
        logic [11:0] a, b, c, d;
        logic chg;

        vt[0] = '{12'h011, 12'h022, 12'h033, 12'h044, 1'b1,
                  40'hA1_11_22_33_44, 72'hA1_11_00_22_00_33_00_44_00};
        vt[1] = '{12'hABC, 12'h123, 12'h000, 12'hFFF, 1'b0,
                  40'hA0_BC_23_00_FF, 72'hA0_BC_0A_23_01_00_00_FF_0F};
        vt[2] = '{12'h5A5, 12'hF0F, 12'h0FF, 12'h800, 1'b1,
                  40'hA1_A5_0F_FF_00, 72'hA1_A5_05_0F_0F_FF_00_00_08};
        gn = '{0, 0};
        dn = '{0, 0};
        dcyc = '{0, 0};

        repeat (3) @(negedge iClk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_data%0d", k), od[k], 8'h00);
            check($sformatf("rst_valid%0d", k), ov[k], 1'b0);
            check($sformatf("rst_busy%0d", k), ob[k], 1'b0);
            check($sformatf("rst_done%0d", k), odn[k], 1'b0);
            check($sformatf("rst_clr%0d", k), ocl[k], 1'b1);
        end
        @(posedge iClk); #2;
        iRst_n = 1'b1;
        iReady = 1'b1;

        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 3; i++) begin
                run_frame(vt[i].w0, vt[i].w1, vt[i].w2, vt[i].w3, vt[i].chg, m, 1'b0, reqc);
                cmp_frame($sformatf("vec%0d_m%0d", i, m), 0, {32'd0, vt[i].e8}, m, reqc);
                cmp_frame($sformatf("vec%0d_m%0d", i, m), 1, vt[i].e12, m, reqc);
            end
        end

        // Abort after two bytes
        @(posedge iClk); #1;
        s0 = 12'h111; s1 = 12'h222; s2 = 12'h333; s3 = 12'h444; iChange = 1'b0;
        gn = '{0, 0};
        dn = '{0, 0};
        iReq = 1'b1;
        @(posedge iClk); #1;
        iReq = 1'b0;
        for (int t = 0; t < 20 && gn[0] < 2; t++) begin
            @(posedge iClk); #1;
        end
        check("abort_reach", gn[0], 2);
        iAbort = 1'b1;
        @(posedge iClk); #1;
        iAbort = 1'b0;
        @(negedge iClk);
        check("abort_valid0", ov[0], 1'b0);
        check("abort_valid1", ov[1], 1'b0);
        check("abort_busy1", ob[1], 1'b0);
        repeat (12) @(negedge iClk);
        check("abort_nodone0", dn[0], 0);
        check("abort_nodone1", dn[1], 0);
        run_frame(vt[1].w0, vt[1].w1, vt[1].w2, vt[1].w3, vt[1].chg, 0, 1'b0, reqc);
        cmp_frame("post_abort", 0, {32'd0, vt[1].e8}, 0, reqc);
        cmp_frame("post_abort", 1, vt[1].e12, 0, reqc);

        // Reset in the middle of a frame
        @(posedge iClk); #1;
        dn = '{0, 0};
        iReq = 1'b1;
        @(posedge iClk); #1;
        iReq = 1'b0;
        repeat (2) begin
            @(posedge iClk); #1;
        end
        iRst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("mrst_data%0d", k), od[k], 8'h00);
            check($sformatf("mrst_valid%0d", k), ov[k], 1'b0);
            check($sformatf("mrst_busy%0d", k), ob[k], 1'b0);
            check($sformatf("mrst_done%0d", k), odn[k], 1'b0);
            check($sformatf("mrst_clr%0d", k), ocl[k], 1'b1);
        end
        #2;
        iRst_n = 1'b1;
        repeat (12) @(negedge iClk);
        check("mrst_nodone0", dn[0], 0);
        check("mrst_nodone1", dn[1], 0);
        check("mrst_idle1", ob[1], 1'b0);
        run_frame(vt[0].w0, vt[0].w1, vt[0].w2, vt[0].w3, vt[0].chg, 0, 1'b0, reqc);
        cmp_frame("post_rst", 0, {32'd0, vt[0].e8}, 0, reqc);
        cmp_frame("post_rst", 1, vt[0].e12, 0, reqc);

        // Random frames with inputs and iReq disturbed during SEND
        for (int r = 0; r < 24; r++) begin
            a = 12'($urandom); b = 12'($urandom);
            c = 12'($urandom); d = 12'($urandom);
            chg = 1'($urandom);
            mode = int'($urandom_range(0, 2));
            run_frame(a, b, c, d, chg, mode, r[0], reqc);
            cmp_frame($sformatf("rnd%0d", r), 0, ref_frame(8, a, b, c, d, chg), mode, reqc);
            cmp_frame($sformatf("rnd%0d", r), 1, ref_frame(12, a, b, c, d, chg), mode, reqc);
        end

        repeat (3) @(negedge iClk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
